// File: rtl/reg_file_ctx.sv
// Register file with accumulator, two bypassed read ports and a single-entry shadow context bank.
// A save/restore sequencer copies one register per cycle to or from the shadow bank.
module reg_file_ctx #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ADDR_W   = 2
) (
  input  logic              Reg_clk,
  input  logic              Reg_rst,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic              RF_we,
  input  logic [DATA_W-1:0] data_in,
  input  logic              Acc_we,
  input  logic [DATA_W-1:0] Acc_in,
  input  logic              ctx_save,
  input  logic              ctx_restore,
  output logic [DATA_W-1:0] data_out_a,
  output logic [DATA_W-1:0] data_out_b,
  output logic [DATA_W-1:0] Acc_out,
  output logic              busy,
  output logic              ctx_valid
);

  localparam int IDX_W = $clog2(NUM_REGS + 1);

  typedef enum logic [1:0] {IDLE, SAVE, RESTORE} state_t;

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] regs   [NUM_REGS];
  logic [DATA_W-1:0] shadow [NUM_REGS];
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] shadow_acc;
  logic              busy_q;
  logic              valid_q;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic              wr_sel_ok;

  assign busy      = busy_q;
  assign ctx_valid = valid_q;
  assign Acc_out   = acc;
  assign wr_sel_ok = (int'(wr_sel) < NUM_REGS);

  // Selects beyond the implemented registers read as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel_a == ADDR_W'(i)) rd_a = regs[i];
      if (rd_sel_b == ADDR_W'(i)) rd_b = regs[i];
    end
  end

  always_comb begin
    data_out_a = rd_a;
    data_out_b = rd_b;
    if (RF_we && !busy_q && wr_sel_ok && (wr_sel == rd_sel_a)) data_out_a = data_in;
    if (RF_we && !busy_q && wr_sel_ok && (wr_sel == rd_sel_b)) data_out_b = data_in;
  end

  // Writes and requests are only honoured in IDLE; idx == NUM_REGS is the accumulator step.
  always_ff @(posedge Reg_clk or posedge Reg_rst) begin
    if (Reg_rst) begin
      state      <= IDLE;
      idx        <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      acc        <= '0;
      shadow_acc <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i]   <= '0;
        shadow[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (RF_we && (wr_sel == ADDR_W'(i))) regs[i] <= data_in;
          end
          if (Acc_we) acc <= Acc_in;
          idx <= '0;
          if (ctx_save) begin
            state   <= SAVE;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
          end else if (ctx_restore && valid_q) begin
            state  <= RESTORE;
            busy_q <= 1'b1;
          end
        end
        SAVE: begin
          if (idx == IDX_W'(NUM_REGS)) begin
            shadow_acc <= acc;
            valid_q    <= 1'b1;
            busy_q     <= 1'b0;
            idx        <= '0;
            state      <= IDLE;
          end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (idx == IDX_W'(i)) shadow[i] <= regs[i];
            end
            idx <= idx + 1'b1;
          end
        end
        RESTORE: begin
          if (idx == IDX_W'(NUM_REGS)) begin
            acc    <= shadow_acc;
            busy_q <= 1'b0;
            idx    <= '0;
            state  <= IDLE;
          end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (idx == IDX_W'(i)) regs[i] <= shadow[i];
            end
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          idx    <= '0;
        end
      endcase
    end
  end

endmodule
